// File: rtl/tex_column_fetcher_if.sv
// Column fetcher bus: descriptor in, texel request out,
// texel return in, framebuffer pixel out.
interface tex_column_fetcher_if;
  logic        col_valid_in;
  logic        col_ready_out;
  logic [8:0]  hcount_ray_in;
  logic [15:0] wallX_in;
  logic [7:0]  line_height_in;
  logic [3:0]  texture_in;
  logic        side_in;
  logic        valid_req_out;
  logic [15:0] wallX_out;
  logic [7:0]  vcount_ray_out;
  logic [3:0]  texture_out;
  logic [15:0] tex_pixel_in;
  logic        pixel_valid_out;
  logic [15:0] pixel_out;
  logic [8:0]  col_out;
  logic [7:0]  row_out;

  modport master (
    input  col_valid_in,
    input  hcount_ray_in,
    input  wallX_in,
    input  line_height_in,
    input  texture_in,
    input  side_in,
    input  tex_pixel_in,
    output col_ready_out,
    output valid_req_out,
    output wallX_out,
    output vcount_ray_out,
    output texture_out,
    output pixel_valid_out,
    output pixel_out,
    output col_out,
    output row_out
  );

  modport slave (
    output col_valid_in,
    output hcount_ray_in,
    output wallX_in,
    output line_height_in,
    output texture_in,
    output side_in,
    output tex_pixel_in,
    input  col_ready_out,
    input  valid_req_out,
    input  wallX_out,
    input  vcount_ray_out,
    input  texture_out,
    input  pixel_valid_out,
    input  pixel_out,
    input  col_out,
    input  row_out
  );
endinterface

// File: rtl/tex_column_fetcher.sv
// Per-column texel request / pixel emitter for one screen column.
// Optional TEX_SHADE_EN halves wall pixel channels on Y-side hits.
module tex_column_fetcher #(
  parameter int unsigned SCREEN_HEIGHT = 180,
  parameter logic [15:0] CEIL_COLOR    = 16'h0000,
  parameter logic [15:0] FLOOR_COLOR   = 16'h4208,
  parameter logic [15:0] WALL_COLOR    = 16'hFFFF,
  parameter int unsigned TEX_LATENCY   = 2
) (
  input logic                  pixel_clk_in,
  input logic                  rst_in,
  tex_column_fetcher_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, DIVIDE, EMIT, DRAIN
  } state_e;

  typedef enum logic [1:0] {
    RC_CEIL, RC_FLOOR, RC_TEX, RC_FLAT
  } rclass_e;

  typedef struct packed {
    logic       vld;
    rclass_e    rc;
    logic [7:0] row;
  } slot_t;

  localparam logic [7:0]  SH       = 8'(SCREEN_HEIGHT);
  localparam logic [7:0]  LAST_ROW = 8'(SCREEN_HEIGHT - 1);
  localparam logic [7:0]  LAST_DRN = 8'(TEX_LATENCY - 1);
  localparam logic [7:0]  LAST_DIV = 8'd15;
  localparam logic [15:0] DIVIDEND = 16'(SCREEN_HEIGHT * 256);

  state_e      state_q, state_d;
  logic        run_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  h_q;
  logic [8:0]  col_q;
  logic [15:0] wallx_q;
  logic [3:0]  tex_q;
  logic [15:0] quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] acc_q, acc_d;
  slot_t       pipe_q [TEX_LATENCY];
  slot_t       push, tail;
  logic        accept, req;
  logic        textured, in_wall;
  logic [7:0]  h_clamp, ds, de;
  logic [8:0]  rem_sh, rem_sub;
  logic        rem_ge;
  logic [15:0] wall_px, px;

  assign accept  = bus.col_valid_in
                && bus.col_ready_out;
  assign h_clamp = (bus.line_height_in > SH)
                 ? SH : bus.line_height_in;
  assign ds      = (SH - h_q) >> 1;
  assign de      = ds + h_q;
  assign in_wall = (cnt_q >= ds) && (cnt_q < de);
  assign textured = (tex_q == 4'd3)
                 || (tex_q == 4'd4)
                 || (tex_q == 4'd5);

  // one restoring-division step per DIVIDE cycle
  assign rem_sh  = {rem_q, quo_q[15]};
  assign rem_ge  = rem_sh >= {1'b0, h_q};
  assign rem_sub = rem_sh - {1'b0, h_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    push    = '0;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DIVIDE;
          cnt_d   = 8'd0;
          quo_d   = DIVIDEND;
          rem_d   = 8'd0;
        end
      end
      DIVIDE: begin
        quo_d = {quo_q[14:0], rem_ge};
        rem_d = rem_ge ? rem_sub[7:0]
                       : rem_sh[7:0];
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_DIV) begin
          state_d = EMIT;
          cnt_d   = 8'd0;
          acc_d   = 16'd0;
        end
      end
      EMIT: begin
        push.vld = 1'b1;
        push.row = cnt_q;
        unique case (1'b1)
          cnt_q < ds:  push.rc = RC_CEIL;
          cnt_q >= de: push.rc = RC_FLOOR;
          in_wall && textured: begin
            push.rc = RC_TEX;
            req     = 1'b1;
            acc_d   = acc_q + quo_q;
          end
          in_wall && !textured:
            push.rc = RC_FLAT;
        endcase
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_ROW) begin
          state_d = DRAIN;
          cnt_d   = 8'd0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_DRN) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      h_q     <= '0;
      col_q   <= '0;
      wallx_q <= '0;
      tex_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      for (int i = 0; i < int'(TEX_LATENCY); i++)
        pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      pipe_q[0] <= push;
      for (int i = 1; i < int'(TEX_LATENCY); i++)
        pipe_q[i] <= pipe_q[i-1];
      if (accept) begin
        h_q     <= h_clamp;
        col_q   <= bus.hcount_ray_in;
        wallx_q <= bus.wallX_in;
        tex_q   <= bus.texture_in;
      end
    end
  end

`ifdef TEX_SHADE_EN
  logic side_q;

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_in)
      side_q <= 1'b0;
    else if (accept)
      side_q <= bus.side_in;
  end
`else
  logic side_unused;

  assign side_unused = bus.side_in;
`endif

  assign tail = pipe_q[TEX_LATENCY-1];

  always_comb begin
    wall_px = (tail.rc == RC_TEX)
            ? bus.tex_pixel_in : WALL_COLOR;
`ifdef TEX_SHADE_EN
    if (side_q)
      wall_px = (wall_px >> 1) & 16'h7BEF;
`endif
    px = 16'd0;
    if (tail.vld) begin
      unique case (tail.rc)
        RC_CEIL:  px = CEIL_COLOR;
        RC_FLOOR: px = FLOOR_COLOR;
        RC_TEX:   px = wall_px;
        RC_FLAT:  px = wall_px;
      endcase
    end
  end

  assign bus.col_ready_out   = run_q
                            && (state_q == IDLE);
  assign bus.valid_req_out   = req;
  assign bus.vcount_ray_out  = req ? acc_q[15:8]
                                   : 8'd0;
  assign bus.wallX_out       = wallx_q;
  assign bus.texture_out     = tex_q;
  assign bus.pixel_valid_out = tail.vld;
  assign bus.row_out         = tail.row;
  assign bus.col_out         = tail.vld ? col_q
                                        : 9'd0;
  assign bus.pixel_out       = px;
endmodule
